// File: rtl/ysyx_25020047_lsu_dmem_if.sv
// -----------------------------------------------------------------------------
// ysyx_25020047_lsu_dmem_if
// Request/response bundle between the execute stage (master) and the data
// memory LSU block (slave).
//
// Signals
//   req_valid  master->slave  execute stage presents a memory request
//   req_ready  slave->master  block accepts a request this cycle
//   req_read   master->slave  load request (lw/lbu)
//   req_write  master->slave  store request (sw/sb)
//   req_byte   master->slave  1 = byte access, 0 = word access
//   req_addr   master->slave  32-bit byte address
//   req_wdata  master->slave  store data (sb uses [7:0])
//   rsp_valid  slave->master  response held on rsp_rdata/rsp_err
//   rsp_ready  master->slave  consumer takes the response
//   rsp_rdata  slave->master  load data (zero for stores and errors)
//   rsp_err    slave->master  request faulted, memory untouched
// -----------------------------------------------------------------------------
interface ysyx_25020047_lsu_dmem_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_read;
   logic        req_write;
   logic        req_byte;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_read, req_write, req_byte, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_read, req_write, req_byte, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/ysyx_25020047_lsu_dmem.sv
// -----------------------------------------------------------------------------
// ysyx_25020047_lsu_dmem
// Single-outstanding load/store unit with an internal word-organised data
// memory. A request is accepted only in IDLE, waits LATENCY cycles in BUSY,
// executes on the edge that raises rsp_valid, then holds the response in RESP
// until the consumer takes it.
//
// Parameters
//   ADDR_BASE    byte address of memory word 0
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 2)
//   LATENCY      accept-to-rsp_valid cycles, 1..15
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset (memory contents are kept)
//   bus          ysyx_25020047_lsu_dmem_if.slave request/response bundle
//
// Build option
//   YSYX_25020047_LSU_ALIGN_CHECK_EN  when defined, misaligned word accesses
//   fault; otherwise word accesses ignore addr[1:0].
// -----------------------------------------------------------------------------
module ysyx_25020047_lsu_dmem #(
   parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input logic                     clk,
   input logic                     rst,
   ysyx_25020047_lsu_dmem_if.slave bus
);

   localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] SPAN_BYTES = 33'(64'(DEPTH_WORDS) * 64'd4);
   localparam logic [3:0]  CNT_LOAD   = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Extract byte lane 'lane' of a word.
   function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
      logic [7:0] b;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         2'd3:    b = word[31:24];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // Replace byte lane 'lane' of a word, keeping the other lanes.
   function automatic logic [31:0] merge_byte(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [7:0] b);
      logic [31:0] w;
      w = word;
      case (lane)
         2'd0:    w[7:0]   = b;
         2'd1:    w[15:8]  = b;
         2'd2:    w[23:16] = b;
         2'd3:    w[31:24] = b;
         default: w = word;
      endcase
      return w;
   endfunction

   state_e       state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [31:0]  addr_q, addr_d;
   logic [31:0]  wdata_q, wdata_d;
   logic         read_q, read_d;
   logic         write_q, write_d;
   logic         byte_q, byte_d;
   logic         rsp_valid_q, rsp_valid_d;
   logic [31:0]  rsp_rdata_q, rsp_rdata_d;
   logic         rsp_err_q, rsp_err_d;

   logic [31:0]  mem_q [DEPTH_WORDS];

   logic         req_ready_s;
   logic [32:0]  off_s;
   logic         in_range_s;
   logic [IDX_W-1:0] idx_s;
   logic         op_bad_s;
   logic         misalign_s;
   logic         err_s;
   logic [31:0]  word_s;
   logic [31:0]  load_data_s;
   logic [31:0]  store_word_s;
   logic         exec_s;
   logic         mem_we_s;

   assign req_ready_s   = (state_q == ST_IDLE) && !rst;
   assign bus.req_ready = req_ready_s;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

   // Decode the latched request: range, opcode sanity, alignment, data paths.
   always_comb begin
      // 33-bit offset: bit 32 set means the address lies below ADDR_BASE.
      off_s      = {1'b0, addr_q} - {1'b0, ADDR_BASE};
      in_range_s = !off_s[32] && (off_s < SPAN_BYTES);
      idx_s      = off_s[IDX_W+1:2];
      op_bad_s   = (read_q == write_q);
`ifdef YSYX_25020047_LSU_ALIGN_CHECK_EN
      misalign_s = !byte_q && (addr_q[1:0] != 2'b00);
`else
      misalign_s = 1'b0;
`endif
      err_s      = op_bad_s || !in_range_s || misalign_s;
      word_s     = mem_q[idx_s];
      if (byte_q) begin
         load_data_s  = {24'h00_0000, lane_byte(word_s, addr_q[1:0])};
         store_word_s = merge_byte(word_s, addr_q[1:0], wdata_q[7:0]);
      end else begin
         load_data_s  = word_s;
         store_word_s = wdata_q;
      end
      exec_s   = (state_q == ST_BUSY) && (cnt_q == 4'd0);
      mem_we_s = exec_s && !err_s && write_q && !rst;
   end

   // Next-state and response logic of the IDLE/BUSY/RESP controller.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      read_d      = read_q;
      write_d     = write_q;
      byte_d      = byte_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid && req_ready_s) begin
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               read_d  = bus.req_read;
               write_d = bus.req_write;
               byte_d  = bus.req_byte;
               cnt_d   = CNT_LOAD;
               state_d = ST_BUSY;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (cnt_q == 4'd0) begin
               // Access executes on this edge; the store lands in the memory process.
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = err_s;
               if (err_s || !read_q) begin
                  rsp_rdata_d = 32'h0000_0000;
               end else begin
                  rsp_rdata_d = load_data_s;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
               rsp_rdata_d = 32'h0000_0000;
               rsp_err_d   = 1'b0;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            cnt_d       = 4'd0;
            rsp_valid_d = 1'b0;
            rsp_rdata_d = 32'h0000_0000;
            rsp_err_d   = 1'b0;
         end
      endcase
   end

   // Controller state, latched request and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         addr_q      <= 32'h0000_0000;
         wdata_q     <= 32'h0000_0000;
         read_q      <= 1'b0;
         write_q     <= 1'b0;
         byte_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0000_0000;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         read_q      <= read_d;
         write_q     <= write_d;
         byte_q      <= byte_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Data array write port; deliberately not reset so contents survive rst.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[idx_s] <= store_word_s;
      end
   end

endmodule

// File: tb/tb_ysyx_25020047_lsu_dmem.sv
// -----------------------------------------------------------------------------
// tb_ysyx_25020047_lsu_dmem
// Self-checking bench for ysyx_25020047_lsu_dmem: directed scenarios followed
// by randomized requests compared against a byte-level reference memory.
// -----------------------------------------------------------------------------
module tb_ysyx_25020047_lsu_dmem;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          DEPTH = 1024;
   localparam int          LAT   = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ysyx_25020047_lsu_dmem_if bif();

   ysyx_25020047_lsu_dmem #(
      .ADDR_BASE   (BASE),
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] ref_mem [DEPTH];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: apply one request to ref_mem and return the expected response.
   task automatic ref_access(input bit rd, input bit wr, input bit by,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output bit err, output logic [31:0] rdata);
      longint unsigned a;
      int              idx;
      int              sh;
      a     = longint'(addr);
      err   = (rd == wr);
      if (a < longint'(BASE) || (a - longint'(BASE)) >= 64'(4 * DEPTH)) err = 1'b1;
`ifdef YSYX_25020047_LSU_ALIGN_CHECK_EN
      if (!by && (a % 4) != 0) err = 1'b1;
`endif
      rdata = 32'h0;
      if (!err) begin
         idx = int'((a - longint'(BASE)) / 4);
         sh  = 8 * int'(a % 4);
         if (wr) begin
            if (by) ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << sh)) | ({24'h0, wdata[7:0]} << sh);
            else    ref_mem[idx] = wdata;
         end else begin
            if (by) rdata = (ref_mem[idx] >> sh) & 32'hFF;
            else    rdata = ref_mem[idx];
         end
      end
   endtask

   // Drive one request, check latency, hold behaviour and handshake release.
   task automatic run_txn(input string tag, input bit rd, input bit wr, input bit by,
                          input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                          output logic [31:0] got_rdata, output logic got_err);
      bit          e_err;
      logic [31:0] e_rd;
      int          lat;
      @(negedge clk);
      bif.req_valid = 1'b1;
      bif.req_read  = rd;
      bif.req_write = wr;
      bif.req_byte  = by;
      bif.req_addr  = addr;
      bif.req_wdata = wdata;
      check_eq({tag, "/ready"}, 32'(bif.req_ready), 32'd1);
      @(posedge clk);
      #1;
      // Scramble the inputs: the latched request must not follow them.
      bif.req_valid = 1'b0;
      bif.req_read  = 1'($urandom);
      bif.req_write = 1'($urandom);
      bif.req_byte  = 1'($urandom);
      bif.req_addr  = BASE + 32'($urandom_range(0, 63));
      bif.req_wdata = $urandom;
      ref_access(rd, wr, by, addr, wdata, e_err, e_rd);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!bif.rsp_valid && lat < 40);
      check_eq({tag, "/latency"}, 32'(lat), 32'(LAT));
      check_eq({tag, "/err"}, 32'(bif.rsp_err), 32'(e_err));
      check_eq({tag, "/rdata"}, bif.rsp_rdata, e_rd);
      got_rdata = bif.rsp_rdata;
      got_err   = bif.rsp_err;
      for (int h = 0; h < hold; h++) begin
         // A store presented while a response is pending must be ignored.
         bif.req_valid = 1'b1;
         bif.req_read  = 1'b0;
         bif.req_write = 1'b1;
         bif.req_byte  = 1'b0;
         bif.req_addr  = BASE + 32'h10;
         bif.req_wdata = $urandom;
         @(posedge clk);
         #1;
         check_eq({tag, "/hold_valid"}, 32'(bif.rsp_valid), 32'd1);
         check_eq({tag, "/hold_rdata"}, bif.rsp_rdata, e_rd);
         check_eq({tag, "/hold_err"}, 32'(bif.rsp_err), 32'(e_err));
         check_eq({tag, "/hold_ready"}, 32'(bif.req_ready), 32'd0);
      end
      bif.req_valid = 1'b0;
      bif.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bif.rsp_ready = 1'b0;
      check_eq({tag, "/rel_valid"}, 32'(bif.rsp_valid), 32'd0);
      check_eq({tag, "/rel_rdata"}, bif.rsp_rdata, 32'h0);
      check_eq({tag, "/rel_err"}, 32'(bif.rsp_err), 32'd0);
   endtask

   initial begin
      logic [31:0] rdv;
      logic        erv;
      logic [31:0] prior;
      rst           = 1'b1;
      bif.req_valid = 1'b0;
      bif.req_read  = 1'b0;
      bif.req_write = 1'b0;
      bif.req_byte  = 1'b0;
      bif.req_addr  = 32'h0;
      bif.req_wdata = 32'h0;
      bif.rsp_ready = 1'b0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst/req_ready", 32'(bif.req_ready), 32'd0);
      check_eq("rst/rsp_valid", 32'(bif.rsp_valid), 32'd0);
      check_eq("rst/rsp_err", 32'(bif.rsp_err), 32'd0);
      check_eq("rst/rsp_rdata", bif.rsp_rdata, 32'h0);
      rst = 1'b0;
      #1;
      check_eq("idle/req_ready", 32'(bif.req_ready), 32'd1);

      // Initialise the test window and the last word of the array.
      for (int i = 0; i < 16; i++)
         run_txn("init", 1'b0, 1'b1, 1'b0, BASE + 32'(4 * i), $urandom, 0, rdv, erv);
      run_txn("init_top", 1'b0, 1'b1, 1'b0, BASE + 32'(4 * (DEPTH - 1)), $urandom, 0, rdv, erv);

      // Word store then load.
      run_txn("sw10", 1'b0, 1'b1, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 0, rdv, erv);
      check_eq("sw10/err_const", 32'(erv), 32'd0);
      run_txn("lw10", 1'b1, 1'b0, 1'b0, 32'h8000_0010, 32'h0, 0, rdv, erv);
      check_eq("lw10/const", rdv, 32'hDEAD_BEEF);

      // Byte store merges into one lane; byte load zero-extends.
      run_txn("sb12", 1'b0, 1'b1, 1'b1, 32'h8000_0012, 32'h0000_0055, 0, rdv, erv);
      run_txn("lw10b", 1'b1, 1'b0, 1'b0, 32'h8000_0010, 32'h0, 0, rdv, erv);
      check_eq("lw10b/const", rdv, 32'hDE55_BEEF);
      run_txn("lbu13", 1'b1, 1'b0, 1'b1, 32'h8000_0013, 32'h0, 0, rdv, erv);
      check_eq("lbu13/const", rdv, 32'h0000_00DE);

      // Back-pressure: response held 5 cycles, new requests refused.
      run_txn("hold5", 1'b1, 1'b0, 1'b0, 32'h8000_0010, 32'h0, 5, rdv, erv);

      // Faulting requests leave memory unchanged.
      run_txn("lw_below", 1'b1, 1'b0, 1'b0, 32'h7FFF_FFFC, 32'h0, 0, rdv, erv);
      check_eq("lw_below/err_const", 32'(erv), 32'd1);
      run_txn("lw_above", 1'b1, 1'b0, 1'b0, BASE + 32'(4 * DEPTH), 32'h0, 0, rdv, erv);
      check_eq("lw_above/err_const", 32'(erv), 32'd1);
      run_txn("rw_both", 1'b1, 1'b1, 1'b0, 32'h8000_0010, 32'h1111_2222, 0, rdv, erv);
      check_eq("rw_both/err_const", 32'(erv), 32'd1);
      run_txn("rw_none", 1'b0, 1'b0, 1'b0, 32'h8000_0010, 32'h3333_4444, 0, rdv, erv);
      run_txn("sw_above", 1'b0, 1'b1, 1'b0, BASE + 32'(4 * DEPTH), 32'h5555_6666, 0, rdv, erv);
      run_txn("lw10c", 1'b1, 1'b0, 1'b0, 32'h8000_0010, 32'h0, 0, rdv, erv);
      check_eq("lw10c/const", rdv, 32'hDE55_BEEF);

      // Misaligned word load.
      run_txn("lw11", 1'b1, 1'b0, 1'b0, 32'h8000_0011, 32'h0, 0, rdv, erv);
`ifdef YSYX_25020047_LSU_ALIGN_CHECK_EN
      check_eq("lw11/err_const", 32'(erv), 32'd1);
`else
      check_eq("lw11/const", rdv, 32'hDE55_BEEF);
`endif

      // Reset one cycle after accepting a store: no response, no write.
      prior = ref_mem[8];
      @(negedge clk);
      bif.req_valid = 1'b1;
      bif.req_read  = 1'b0;
      bif.req_write = 1'b1;
      bif.req_byte  = 1'b0;
      bif.req_addr  = 32'h8000_0020;
      bif.req_wdata = 32'h1234_5678;
      @(posedge clk);
      #1;
      bif.req_valid = 1'b0;
      rst = 1'b1;
      check_eq("rstbusy/req_ready", 32'(bif.req_ready), 32'd0);
      @(posedge clk);
      #1;
      check_eq("rstbusy/rsp_valid", 32'(bif.rsp_valid), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check_eq("rstbusy/no_rsp", 32'(bif.rsp_valid), 32'd0);
      end
      run_txn("lw20", 1'b1, 1'b0, 1'b0, 32'h8000_0020, 32'h0, 0, rdv, erv);
      check_eq("lw20/prior", rdv, prior);

      // Randomized traffic against the reference memory.
      for (int n = 0; n < 150; n++) begin
         int          sel;
         int          op;
         bit          rd;
         bit          wr;
         logic [31:0] a;
         sel = int'($urandom_range(0, 9));
         if (sel < 8)       a = BASE + 32'($urandom_range(0, 63));
         else if (sel == 8) a = ($urandom_range(0, 1) == 0) ? BASE - 32'(4 * $urandom_range(1, 8))
                                                          : BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 15));
         else               a = BASE + 32'(4 * DEPTH - 4) + 32'($urandom_range(0, 3));
         op = int'($urandom_range(0, 9));
         rd = (op == 0) || (op >= 2 && op <= 5);
         wr = (op == 0) || (op >= 6);
         run_txn("rand", rd, wr, 1'($urandom), a, $urandom, int'($urandom_range(0, 3)), rdv, erv);
      end

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
